// File: rtl/accum_stream_30.sv
// Streaming packet accumulator: adds/subtracts 30-bit beats per packet through a
// Kogge-Stone prefix adder and holds the packet result until the consumer takes it.

module prefix_adder_30 (
  input  logic [29:0] a,
  input  logic [29:0] b,
  input  logic        cin,
  output logic [29:0] sum,
  output logic        cout
);

  logic [29:0] prop;
  logic [29:0] grp_g;
  logic [29:0] grp_p;
  logic [29:0] nxt_g;
  logic [29:0] nxt_p;
  logic [30:0] carry;

  // Five doubling levels reduce each bit to its group generate/propagate over bits [i:0]
  always_comb begin
    prop  = a ^ b;
    grp_g = a & b;
    grp_p = prop;
    nxt_g = '0;
    nxt_p = '0;
    for (int lvl = 0; lvl < 5; lvl++) begin
      nxt_g = grp_g;
      nxt_p = grp_p;
      for (int i = 0; i < 30; i++) begin
        if (i >= (1 << lvl)) begin
          nxt_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
          nxt_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
        end
      end
      grp_g = nxt_g;
      grp_p = nxt_p;
    end
    carry = {grp_g | (grp_p & {30{cin}}), cin};
    sum   = prop ^ carry[29:0];
    cout  = carry[30];
  end

endmodule

module accum_stream_30 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [29:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [29:0]      out_sum,
  output logic             out_flag,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [29:0]      acc;
  logic [29:0]      a_op;
  logic [29:0]      b_op;
  logic [29:0]      add_sum;
  logic             add_cout;
  logic             carry_evt;
  logic             flag;
  logic             flag_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             take_result;

  assign accept      = in_valid & in_ready;
  assign take_result = out_valid & out_ready;

  // Subtraction is a + ~b + 1, so a missing carry-out means a borrow occurred
  assign a_op      = (state == IDLE) ? '0 : acc;
  assign b_op      = in_sub ? ~in_data : in_data;
  assign carry_evt = in_sub ? ~add_cout : add_cout;
  assign flag_next = (state == IDLE) ? carry_evt : (flag | carry_evt);
  assign cnt_next  = (state == IDLE) ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);

  prefix_adder_30 u_adder (
    .a    (a_op),
    .b    (b_op),
    .cin  (in_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACC: if (accept) state_next = in_last ? HOLD : ACC;
      HOLD:      if (take_result) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != HOLD);
  end

  // Running state is cleared on release so the next packet starts from a clean slate
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      flag      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_flag  <= 1'b0;
      out_count <= '0;
    end else if (accept) begin
      acc  <= add_sum;
      flag <= flag_next;
      cnt  <= cnt_next;
      if (in_last) begin
        out_sum   <= add_sum;
        out_flag  <= flag_next;
        out_count <= cnt_next;
        out_valid <= 1'b1;
      end
    end else if (take_result) begin
      out_valid <= 1'b0;
      acc       <= '0;
      flag      <= 1'b0;
      cnt       <= '0;
    end
  end

endmodule

// File: tb/tb_accum_stream_30.sv
// Randomized and directed checks of accum_stream_30 against an arithmetic packet model;
// a second instance with a 2-bit counter exercises count saturation.

module tb_accum_stream_30;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_sum;
  logic        out_flag;
  logic [7:0]  out_count;

  logic        in_ready2;
  logic        out_valid2;
  logic [29:0] out_sum2;
  logic        out_flag2;
  logic [1:0]  out_count2;

  int tests;
  int failures;

  logic [29:0] pktData[$];
  bit          pktSub[$];

  accum_stream_30 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_flag(out_flag), .out_count(out_count)
  );

  accum_stream_30 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_flag(out_flag2), .out_count(out_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic addBeat(input logic [29:0] d, input bit s);
    pktData.push_back(d);
    pktSub.push_back(s);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_ready"}, in_ready, 1);
    checkOutput({tag, "_sum"},   out_sum, 0);
    checkOutput({tag, "_flag"},  out_flag, 0);
    checkOutput({tag, "_count"}, out_count, 0);
    checkOutput({tag, "_valid2"}, out_valid2, 0);
  endtask

  // Sends the queued packet, then checks result, hold stability and release
  task automatic applyStimulus(input string tag, input int holdCycles, input bit gaps);
    longint modulus;
    longint total;
    bit     flagModel;
    int     n;
    modulus   = 64'd1 << 30;
    total     = 0;
    flagModel = 0;
    n         = pktData.size();
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid  = 1'b0;
        in_data   = 30'($urandom);
        in_sub    = 1'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'($urandom);
        tick();
      end
      in_valid  = 1'b1;
      in_data   = pktData[k];
      in_sub    = pktSub[k];
      in_last   = (k == n - 1);
      out_ready = 1'($urandom);
      checkOutput({tag, "_beat_ready"}, in_ready, 1);
      if (pktSub[k]) begin
        if (longint'(pktData[k]) > total) flagModel = 1;
        total = (total + modulus - longint'(pktData[k])) % modulus;
      end else begin
        total = total + longint'(pktData[k]);
        if (total >= modulus) flagModel = 1;
        total = total % modulus;
      end
      tick();
    end
    in_valid  = 1'($urandom);
    in_data   = 30'($urandom);
    in_sub    = 1'($urandom);
    in_last   = 1'($urandom);
    out_ready = (holdCycles == 0);
    checkOutput({tag, "_valid"},  out_valid, 1);
    checkOutput({tag, "_sum"},    out_sum, 32'(total));
    checkOutput({tag, "_flag"},   out_flag, 32'(flagModel));
    checkOutput({tag, "_count"},  out_count, (n > 255) ? 255 : n);
    checkOutput({tag, "_count2"}, out_count2, (n > 3) ? 3 : n);
    checkOutput({tag, "_sum2"},   out_sum2, 32'(total));
    checkOutput({tag, "_hold_ready"}, in_ready, 0);
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      in_valid = 1'($urandom);
      in_data  = 30'($urandom);
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
      checkOutput({tag, "_hold_sum"},   out_sum, 32'(total));
      checkOutput({tag, "_hold_flag"},  out_flag, 32'(flagModel));
      checkOutput({tag, "_hold_count"}, out_count, (n > 255) ? 255 : n);
      checkOutput({tag, "_hold_rdy"},   in_ready, 0);
      out_ready = (h == holdCycles - 1);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, out_valid, 0);
    checkOutput({tag, "_idle_ready"}, in_ready, 1);
    pktData.delete();
    pktSub.delete();
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkIdleOutputs("reset");

    addBeat(30'd5, 0); addBeat(30'd7, 0); addBeat(30'd100, 0);
    applyStimulus("three_add", 0, 0);

    addBeat(30'h3FFFFFFF, 0); addBeat(30'd2, 0);
    applyStimulus("wrap_add", 1, 0);

    addBeat(30'd10, 0); addBeat(30'd3, 1);
    applyStimulus("sub_ok", 0, 0);
    addBeat(30'd3, 0); addBeat(30'd10, 1);
    applyStimulus("sub_borrow", 2, 0);

    addBeat(30'd42, 0);
    applyStimulus("single_hold", 5, 0);

    for (int k = 0; k < 5; k++) addBeat(30'd1, 0);
    applyStimulus("sat_small", 0, 0);

    // Reset in the middle of a packet discards it
    in_valid = 1'b1; in_data = 30'd1; in_sub = 1'b0; in_last = 1'b0;
    tick();
    in_data = 30'd2;
    tick();
    in_data = 30'd3; in_last = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checkIdleOutputs("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("rst_mid_novalid", out_valid, 0);
    end
    addBeat(30'd9, 0);
    applyStimulus("after_rst", 0, 0);

    // Reset while a result is pending, with a concurrent handshake
    in_valid = 1'b1; in_data = 30'd20; in_sub = 1'b0; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("pend_valid", out_valid, 1);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    checkIdleOutputs("rst_hold");

    for (int k = 0; k < 300; k++) addBeat(30'($urandom), 1'($urandom));
    applyStimulus("long_sat", 1, 0);

    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) addBeat(30'h3FFFFFFF - 30'($urandom_range(0, 3)), 1'($urandom));
        else addBeat(30'($urandom), 1'($urandom));
      end
      applyStimulus("random", $urandom_range(0, 3), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/accum_stream_30.md
ACCUM_STREAM_30 -- requirements
Module: accum_stream_30

Interface
REQ-001 Parameter: CNT_W, 8, width of beat counter (legal range 2..16).
REQ-002 The port list SHALL be, in order:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat
- in_data  input  30  unsigned operand
- in_sub  input  1  1 = subtract in_data from running total, 0 = add
- in_last  input  1  final beat of packet
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  30  packet result, modulo 2^30
- out_flag  output  1  sticky carry/borrow seen during packet
- out_count  output  CNT_W  beats in packet, saturating
REQ-003 Clocking and reset SHALL be one clock (clk), with synchronous, active-high reset (rst); no other clock or reset SHALL exist.

Function
REQ-004 The block SHALL compute all additions with one instance of the existing 30-bit prefix adder (ports a, b, cin, sum, cout): a = running total, b = in_data (add) or ~in_data (sub), cin = in_sub.
REQ-005 State machine SHALL be IDLE, ACC, HOLD; encoding free.
REQ-006 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-007 A beat SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; in_data/in_sub/in_last are sampled only then.
REQ-008 Running total operand a SHALL be 0 for the first beat of a packet (state IDLE), else the accumulator register.
REQ-009 Per accepted beat the carry event SHALL be cout when in_sub=0 and ~cout when in_sub=1; the flag register SHALL OR in this event, and SHALL clear to the event value on the first beat.
REQ-010 The beat counter SHALL load 1 on the first beat, increment per accepted beat, and saturate at 2^CNT_W-1 without wrapping.
REQ-011 Accepted beat, in_last=0: accumulator <= adder sum; IDLE->ACC or ACC->ACC.
REQ-012 Accepted beat, in_last=1: out_sum <= adder sum, out_flag <= updated flag, out_count <= updated count, out_valid <= 1, state -> HOLD, next edge; a single-beat packet (IDLE with last) SHALL be legal.
REQ-013 Latency: the result SHALL be visible on the cycle after the last beat is accepted; throughput is one beat per cycle inside a packet.
REQ-014 In HOLD, out_sum/out_flag/out_count/out_valid SHALL remain stable until out_valid=1 and out_ready=1 on an edge; then out_valid <= 0, accumulator, flag and counter <= 0, and state -> IDLE.
REQ-015 out_ready SHALL be ignored while out_valid=0; in_valid with no acceptance (HOLD) SHALL have no effect.
REQ-016 No idle bubble is required after HOLD, but no beat SHALL be accepted on the same edge as the result handshake (in_ready=0 then).
REQ-017 in_valid deasserting mid-packet SHALL stall the accumulation without state change.
REQ-018 Arithmetic SHALL be modulo 2^30; the adder cout SHALL not be output directly.

Reset
REQ-019 rst=1 on an edge SHALL force state IDLE, accumulator/flag/counter 0, out_valid 0, out_sum 0, out_flag 0, out_count 0, overriding any concurrent handshake.
REQ-020 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-021 Reset asserted mid-packet or in HOLD SHALL discard the partial or pending result, and no out_valid SHALL appear for it.

Verification
REQ-022 Beats 5, 7, 100 (add, last on 100), out_ready=1 -> out_sum=112, out_flag=0, out_count=3, out_valid high exactly one cycle.
REQ-023 Beats 0x3FFFFFFF, 2 (add, last) -> out_sum=1, out_flag=1, out_count=2.
REQ-024 Beats 10, sub 3 (last) -> out_sum=7, out_flag=0; then a new packet 3, sub 10 (last) -> out_sum=0x3FFFFFF9, out_flag=1.
REQ-025 Single-beat packet 42, out_ready=0 for 5 cycles -> in_ready=0 and outputs stable at 42/0/1 throughout; release out_ready -> one handshake, then IDLE with in_ready=1.
REQ-026 CNT_W=2, 5 beats of 1 -> out_count=3 (saturated), out_sum=5.
REQ-027 rst pulsed after 2 beats of a 3-beat packet -> no out_valid; the next packet 9 (last) -> out_sum=9, out_count=1.
